// File: rtl/match_pkg.sv
// Shared types and helpers for the match sequencer: FSM states, link event codes, score width.
package match_pkg;

  localparam int SCORE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    COUNTDOWN,
    RALLY,
    HANDOFF,
    REMOTE,
    POINT,
    MATCH_OVER
  } state_t;

  localparam logic [1:0] EV_RETURN = 2'b01;
  localparam logic [1:0] EV_MISS   = 2'b10;

  // Scores stick at full scale instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s == '1) ? s : s + 1'b1;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider producing a one-cycle tick every TICK_DIV cycles; clr holds the count at 0.
module tick_gen #(
  parameter int TICK_DIV = 25000000
) (
  input  logic clk_25MHZ,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam logic [24:0] LAST = 25'(TICK_DIV - 1);

  logic [24:0] cnt;

  assign tick = !clr && (cnt == LAST);

  always_ff @(posedge clk_25MHZ or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 25'd1;
    end
  end

endmodule

// File: rtl/match_sequencer.sv
// Match-level controller for the two-board ping-pong game: countdown, serve, handoff, scoring.
// Define MATCH_DEUCE_EN to require a two-point lead at or beyond WIN_SCORE.
module match_sequencer
  import match_pkg::*;
#(
  parameter int TICK_DIV       = 25000000,
  parameter int COUNT_SECS     = 3,
  parameter int WIN_SCORE      = 5,
  parameter int REMOTE_TIMEOUT = 10
) (
  input  logic               clk_25MHZ,
  input  logic               reset,
  input  logic               start_btn,
  input  logic               local_miss,
  input  logic               ball_send_trigger,
  input  logic [7:0]         ball_vy,
  output logic               game_start,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [7:0]         tx_vy,
  input  logic               rx_valid,
  input  logic [1:0]         rx_event,
  output logic [SCORE_W-1:0] local_score,
  output logic [SCORE_W-1:0] remote_score,
  output logic [1:0]         countdown_digit,
  output logic               match_over,
  output state_t             state_dbg
);

  localparam logic [1:0]         CD_LOAD = 2'(COUNT_SECS);
  localparam logic [7:0]         RT_LAST = 8'(REMOTE_TIMEOUT - 1);

  state_t     state;
  logic       trig_q;
  logic       tick;
  logic       tick_clr;
  logic       trig_edge;
  logic       rx_ret;
  logic       rx_miss;
  logic       win_now;
  logic [7:0] remote_ticks;

  // The divider only runs in the two timed states, so it is already at 0 on entry to either.
  assign tick_clr  = (state != COUNTDOWN) && (state != REMOTE);
  assign trig_edge = ball_send_trigger && !trig_q;
  assign rx_ret    = rx_valid && (rx_event == EV_RETURN);
  assign rx_miss   = rx_valid && (rx_event == EV_MISS);
  assign state_dbg = state;

`ifdef MATCH_DEUCE_EN
  localparam logic [SCORE_W:0] WIN9 = (SCORE_W+1)'(WIN_SCORE);
  logic [SCORE_W:0] l9;
  logic [SCORE_W:0] r9;
  assign l9      = {1'b0, local_score};
  assign r9      = {1'b0, remote_score};
  assign win_now = ((l9 >= WIN9) && (l9 >= r9 + 9'd2)) ||
                   ((r9 >= WIN9) && (r9 >= l9 + 9'd2));
`else
  localparam logic [SCORE_W-1:0] WIN8 = SCORE_W'(WIN_SCORE);
  assign win_now = (local_score == WIN8) || (remote_score == WIN8);
`endif

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk_25MHZ(clk_25MHZ),
    .reset    (reset),
    .clr      (tick_clr),
    .tick     (tick)
  );

  // Link TX handshake: a transfer happens in each cycle where tx_valid && tx_ready; tx_valid and
  // tx_vy hold until then, and tx_ready may be high before tx_valid rises.
  always_ff @(posedge clk_25MHZ or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      trig_q          <= 1'b0;
      game_start      <= 1'b0;
      tx_valid        <= 1'b0;
      tx_vy           <= '0;
      local_score     <= '0;
      remote_score    <= '0;
      countdown_digit <= '0;
      match_over      <= 1'b0;
      remote_ticks    <= '0;
    end else begin
      trig_q     <= ball_send_trigger;
      game_start <= 1'b0;
      case (state)
        IDLE: begin
          if (start_btn) begin
            countdown_digit <= CD_LOAD;
            state           <= COUNTDOWN;
          end
        end
        COUNTDOWN: begin
          if (tick) begin
            if (countdown_digit <= 2'd1) begin
              countdown_digit <= '0;
              game_start      <= 1'b1;
              state           <= RALLY;
            end else begin
              countdown_digit <= countdown_digit - 2'd1;
            end
          end
        end
        RALLY: begin
          // A miss in the same cycle as a send edge means the ball never left.
          if (local_miss) begin
            remote_score <= sat_inc(remote_score);
            state        <= POINT;
          end else if (trig_edge) begin
            tx_vy    <= ball_vy;
            tx_valid <= 1'b1;
            state    <= HANDOFF;
          end
        end
        HANDOFF: begin
          if (tx_ready) begin
            tx_valid     <= 1'b0;
            remote_ticks <= '0;
            state        <= REMOTE;
          end
        end
        REMOTE: begin
          if (rx_ret) begin
            game_start <= 1'b1;
            state      <= RALLY;
          end else if (rx_miss) begin
            local_score <= sat_inc(local_score);
            state       <= POINT;
          end else if (tick) begin
            if (remote_ticks == RT_LAST) begin
              local_score <= sat_inc(local_score);
              state       <= POINT;
            end else begin
              remote_ticks <= remote_ticks + 8'd1;
            end
          end
        end
        POINT: begin
          if (win_now) begin
            match_over <= 1'b1;
            state      <= MATCH_OVER;
          end else begin
            countdown_digit <= CD_LOAD;
            state           <= COUNTDOWN;
          end
        end
        MATCH_OVER: begin
          if (start_btn) begin
            local_score     <= '0;
            remote_score    <= '0;
            match_over      <= 1'b0;
            countdown_digit <= CD_LOAD;
            state           <= COUNTDOWN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_match_sequencer.sv
// Self-checking bench for match_sequencer with short ticks; honours MATCH_DEUCE_EN in its score model.
module tb_match_sequencer;
  import match_pkg::*;

  localparam int TD = 4;
  localparam int CS = 3;
  localparam int WIN = 2;
  localparam int RT = 5;

  logic       clk_25MHZ = 1'b0;
  logic       reset = 1'b1;
  logic       start_btn = 1'b0;
  logic       local_miss = 1'b0;
  logic       ball_send_trigger = 1'b0;
  logic [7:0] ball_vy = '0;
  logic       tx_ready = 1'b0;
  logic       rx_valid = 1'b0;
  logic [1:0] rx_event = '0;
  logic       game_start;
  logic       tx_valid;
  logic [7:0] tx_vy;
  logic [7:0] local_score;
  logic [7:0] remote_score;
  logic [1:0] countdown_digit;
  logic       match_over;
  state_t     state_dbg;

  int n_vec = 0;
  int n_miss = 0;
  int exp_l = 0;
  int exp_r = 0;
  logic [7:0] exp_q[$];

  match_sequencer #(
    .TICK_DIV(TD), .COUNT_SECS(CS), .WIN_SCORE(WIN), .REMOTE_TIMEOUT(RT)
  ) dut (
    .clk_25MHZ(clk_25MHZ), .reset(reset), .start_btn(start_btn), .local_miss(local_miss),
    .ball_send_trigger(ball_send_trigger), .ball_vy(ball_vy), .game_start(game_start),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_vy(tx_vy), .rx_valid(rx_valid),
    .rx_event(rx_event), .local_score(local_score), .remote_score(remote_score),
    .countdown_digit(countdown_digit), .match_over(match_over), .state_dbg(state_dbg)
  );

  always #20 clk_25MHZ = ~clk_25MHZ;

  initial begin
    #2ms;
    $display("FAIL watchdog expired before the test sequence finished");
    $fatal(1);
  end

  // Reference win rule from the match rules.
  function automatic bit model_win(input int l, input int r);
`ifdef MATCH_DEUCE_EN
    return (l >= WIN && l - r >= 2) || (r >= WIN && r - l >= 2);
`else
    return (l == WIN) || (r == WIN);
`endif
  endfunction

  task automatic tick();
    @(posedge clk_25MHZ);
    #1;
  endtask

  task automatic wait_game_start();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (game_start === 1'b1) seen = 1'b1;
      else tick();
    end
    n_vec++;
    if (!seen) begin
      n_miss++;
      $display("FAIL game_start_wait got no pulse want pulse within 40 cycles");
    end
  endtask

  // Drives a fresh trigger edge from RALLY and completes the handshake; returns in REMOTE cycle 0.
  task automatic send_ball(input logic [7:0] vy, input int rdy_delay,
                           output logic [7:0] got, output int xfers);
    ball_send_trigger = 1'b0;
    tx_ready = 1'b0;
    tick();
    ball_vy = vy;
    ball_send_trigger = 1'b1;
    tx_ready = (rdy_delay == 0);
    exp_q.push_back(vy);
    tick();
    ball_vy = 8'($urandom);
    got = '0;
    xfers = 0;
    for (int i = 0; i < rdy_delay + 8 && xfers == 0; i++) begin
      if (i >= rdy_delay) tx_ready = 1'b1;
      if (tx_valid === 1'b1 && tx_ready) begin
        xfers++;
        got = tx_vy;
      end
      tick();
    end
    tx_ready = 1'b0;
  endtask

  // Plays one point from RALLY and returns in the POINT cycle.
  task automatic play_point(input bit local_wins, output logic [7:0] got, output int xfers);
    if (local_wins) begin
      send_ball(8'($urandom), int'($urandom_range(0, 3)), got, xfers);
      if ($urandom_range(0, 1) == 1) begin
        repeat (int'($urandom_range(0, 18))) tick();
        rx_valid = 1'b1;
        rx_event = EV_MISS;
        tick();
        rx_valid = 1'b0;
      end else begin
        repeat (TD * RT) tick();
      end
    end else begin
      got = '0;
      xfers = 0;
      repeat (int'($urandom_range(0, 4))) tick();
      local_miss = 1'b1;
      tick();
      local_miss = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk_25MHZ);
    #1;
    n_vec++;
    if (state_dbg !== IDLE || game_start !== 1'b0 || tx_valid !== 1'b0 || tx_vy !== 8'h00 ||
        local_score !== 8'h00 || remote_score !== 8'h00 || countdown_digit !== 2'd0 ||
        match_over !== 1'b0) begin
      n_miss++;
      $display("FAIL reset_values got st=%0d gs=%b tv=%b vy=%h ls=%0d rs=%0d cd=%0d mo=%b want all 0",
               state_dbg, game_start, tx_valid, tx_vy, local_score, remote_score, countdown_digit, match_over);
    end
    @(negedge clk_25MHZ);
    reset = 1'b0;
    tick();
    local_miss = 1'b1; rx_valid = 1'b1; rx_event = EV_RETURN; ball_send_trigger = 1'b1;
    ball_vy = 8'h55; tx_ready = 1'b1;
    tick();
    local_miss = 1'b0; rx_valid = 1'b0; ball_send_trigger = 1'b0; tx_ready = 1'b0;
    tick();
    n_vec++;
    if (state_dbg !== IDLE || tx_valid !== 1'b0 || game_start !== 1'b0 || remote_score !== 8'h00) begin
      n_miss++;
      $display("FAIL idle_ignores got st=%0d tv=%b gs=%b rs=%0d want IDLE 0 0 0",
               state_dbg, tx_valid, game_start, remote_score);
    end
  endtask

  task automatic test_countdown();
    logic [1:0] want_d;
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    for (int k = 0; k < CS * TD; k++) begin
      want_d = 2'(CS - k / TD);
      n_vec++;
      if (countdown_digit !== want_d || state_dbg !== COUNTDOWN || game_start !== 1'b0) begin
        n_miss++;
        $display("FAIL countdown k=%0d got cd=%0d st=%0d gs=%b want cd=%0d COUNTDOWN gs=0",
                 k, countdown_digit, state_dbg, game_start, want_d);
      end
      if (k == 5) begin
        start_btn = 1'b1; rx_valid = 1'b1; rx_event = EV_MISS; local_miss = 1'b1;
      end else begin
        start_btn = 1'b0; rx_valid = 1'b0; local_miss = 1'b0;
      end
      tick();
    end
    n_vec++;
    if (game_start !== 1'b1 || state_dbg !== RALLY || countdown_digit !== 2'd0) begin
      n_miss++;
      $display("FAIL serve_pulse got gs=%b st=%0d cd=%0d want gs=1 RALLY cd=0",
               game_start, state_dbg, countdown_digit);
    end
    tick();
    n_vec++;
    if (game_start !== 1'b0 || state_dbg !== RALLY) begin
      n_miss++;
      $display("FAIL serve_single got gs=%b st=%0d want gs=0 RALLY", game_start, state_dbg);
    end
  endtask

  task automatic test_handoff();
    logic [7:0] got;
    logic [7:0] want;
    int xfers;
    ball_vy = 8'hFD;
    ball_send_trigger = 1'b1;
    tx_ready = 1'b0;
    exp_q.push_back(8'hFD);
    tick();
    ball_vy = 8'h11;
    for (int k = 0; k < 6; k++) begin
      n_vec++;
      if (tx_valid !== 1'b1 || tx_vy !== 8'hFD || state_dbg !== HANDOFF) begin
        n_miss++;
        $display("FAIL handoff_hold k=%0d got tv=%b vy=%h st=%0d want tv=1 vy=fd HANDOFF",
                 k, tx_valid, tx_vy, state_dbg);
      end
      tick();
    end
    tx_ready = 1'b1;
    xfers = 0;
    got = '0;
    for (int k = 0; k < 6; k++) begin
      if (tx_valid === 1'b1) begin
        xfers++;
        got = tx_vy;
      end
      tick();
    end
    tx_ready = 1'b0;
    want = exp_q.pop_front();
    n_vec++;
    if (xfers != 1 || got !== want) begin
      n_miss++;
      $display("FAIL handoff_xfer got n=%0d vy=%h want n=1 vy=%h", xfers, got, want);
    end
    n_vec++;
    if (state_dbg !== REMOTE || tx_valid !== 1'b0) begin
      n_miss++;
      $display("FAIL handoff_done got st=%0d tv=%b want REMOTE tv=0", state_dbg, tx_valid);
    end
  endtask

  task automatic test_remote_events();
    logic [7:0] got;
    logic [7:0] want;
    int xfers;
    local_miss = 1'b1; start_btn = 1'b1; rx_valid = 1'b1;
    rx_event = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
    tick();
    local_miss = 1'b0; start_btn = 1'b0; rx_valid = 1'b0;
    n_vec++;
    if (state_dbg !== REMOTE || remote_score !== 8'(exp_r) || local_score !== 8'(exp_l)) begin
      n_miss++;
      $display("FAIL remote_ignores got st=%0d ls=%0d rs=%0d want REMOTE %0d %0d",
               state_dbg, local_score, remote_score, exp_l, exp_r);
    end
    repeat (int'($urandom_range(0, 8))) tick();
    rx_valid = 1'b1;
    rx_event = EV_RETURN;
    tick();
    rx_valid = 1'b0;
    n_vec++;
    if (state_dbg !== RALLY || game_start !== 1'b1 || local_score !== 8'(exp_l)) begin
      n_miss++;
      $display("FAIL rx_return got st=%0d gs=%b ls=%0d want RALLY gs=1 ls=%0d",
               state_dbg, game_start, local_score, exp_l);
    end
    for (int k = 0; k < 6; k++) begin
      rx_valid = (k == 2);
      rx_event = EV_MISS;
      tick();
      n_vec++;
      if (state_dbg !== RALLY || tx_valid !== 1'b0 || local_score !== 8'(exp_l)) begin
        n_miss++;
        $display("FAIL held_trigger k=%0d got st=%0d tv=%b ls=%0d want RALLY tv=0 ls=%0d",
                 k, state_dbg, tx_valid, local_score, exp_l);
      end
    end
    rx_valid = 1'b0;
    send_ball(8'($urandom), int'($urandom_range(0, 4)), got, xfers);
    want = exp_q.pop_front();
    n_vec++;
    if (xfers != 1 || got !== want || state_dbg !== REMOTE) begin
      n_miss++;
      $display("FAIL resend got n=%0d vy=%h st=%0d want n=1 vy=%h REMOTE", xfers, got, state_dbg, want);
    end
    repeat (int'($urandom_range(0, 15))) tick();
    rx_valid = 1'b1;
    rx_event = EV_MISS;
    tick();
    rx_valid = 1'b0;
    exp_l++;
    n_vec++;
    if (state_dbg !== POINT || local_score !== 8'(exp_l) || remote_score !== 8'(exp_r)) begin
      n_miss++;
      $display("FAIL rx_miss got st=%0d ls=%0d rs=%0d want POINT %0d %0d",
               state_dbg, local_score, remote_score, exp_l, exp_r);
    end
    tick();
    n_vec++;
    if (state_dbg !== COUNTDOWN || countdown_digit !== 2'(CS)) begin
      n_miss++;
      $display("FAIL restart got st=%0d cd=%0d want COUNTDOWN cd=%0d", state_dbg, countdown_digit, CS);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] got;
    logic [7:0] want;
    int xfers;
    state_t want_s;
    wait_game_start();
    send_ball(8'($urandom), 1, got, xfers);
    want = exp_q.pop_front();
    n_vec++;
    if (xfers != 1 || got !== want) begin
      n_miss++;
      $display("FAIL timeout_xfer got n=%0d vy=%h want n=1 vy=%h", xfers, got, want);
    end
    repeat (TD * RT - 1) tick();
    n_vec++;
    if (state_dbg !== REMOTE || local_score !== 8'(exp_l)) begin
      n_miss++;
      $display("FAIL timeout_early got st=%0d ls=%0d want REMOTE ls=%0d", state_dbg, local_score, exp_l);
    end
    tick();
    exp_l++;
    n_vec++;
    if (state_dbg !== POINT || local_score !== 8'(exp_l)) begin
      n_miss++;
      $display("FAIL timeout_point got st=%0d ls=%0d want POINT ls=%0d", state_dbg, local_score, exp_l);
    end
    tick();
    want_s = model_win(exp_l, exp_r) ? MATCH_OVER : COUNTDOWN;
    n_vec++;
    if (state_dbg !== want_s || match_over !== (want_s == MATCH_OVER)) begin
      n_miss++;
      $display("FAIL timeout_end got st=%0d mo=%b want st=%0d", state_dbg, match_over, want_s);
    end
    if (want_s == MATCH_OVER) begin
      start_btn = 1'b1;
      tick();
      start_btn = 1'b0;
      exp_l = 0;
      exp_r = 0;
      n_vec++;
      if (state_dbg !== COUNTDOWN || local_score !== 8'h00 || remote_score !== 8'h00 || match_over !== 1'b0) begin
        n_miss++;
        $display("FAIL rematch got st=%0d ls=%0d rs=%0d mo=%b want COUNTDOWN 0 0 0",
                 state_dbg, local_score, remote_score, match_over);
      end
    end
    for (int pass = 0; pass < 2; pass++) begin
      wait_game_start();
      send_ball(8'($urandom), int'($urandom_range(0, 2)), got, xfers);
      want = exp_q.pop_front();
      n_vec++;
      if (xfers != 1 || got !== want) begin
        n_miss++;
        $display("FAIL coincide_xfer p=%0d got n=%0d vy=%h want n=1 vy=%h", pass, xfers, got, want);
      end
      repeat (TD * RT - 1) tick();
      rx_valid = 1'b1;
      rx_event = (pass == 0) ? EV_RETURN : EV_MISS;
      tick();
      rx_valid = 1'b0;
      if (pass == 1) exp_l++;
      want_s = (pass == 0) ? RALLY : POINT;
      n_vec++;
      if (state_dbg !== want_s || local_score !== 8'(exp_l) || game_start !== (pass == 0)) begin
        n_miss++;
        $display("FAIL coincide p=%0d got st=%0d ls=%0d gs=%b want st=%0d ls=%0d",
                 pass, state_dbg, local_score, game_start, want_s, exp_l);
      end
    end
    tick();
    want_s = model_win(exp_l, exp_r) ? MATCH_OVER : COUNTDOWN;
    n_vec++;
    if (state_dbg !== want_s || local_score !== 8'(exp_l)) begin
      n_miss++;
      $display("FAIL coincide_after got st=%0d ls=%0d want st=%0d ls=%0d", state_dbg, local_score, want_s, exp_l);
    end
  endtask

  task automatic test_miss_vs_trigger();
    state_t want_s;
    wait_game_start();
    ball_send_trigger = 1'b0;
    tick();
    ball_send_trigger = 1'b1;
    ball_vy = 8'($urandom);
    local_miss = 1'b1;
    tick();
    local_miss = 1'b0;
    exp_r++;
    n_vec++;
    if (state_dbg !== POINT || remote_score !== 8'(exp_r) || tx_valid !== 1'b0) begin
      n_miss++;
      $display("FAIL miss_wins got st=%0d rs=%0d tv=%b want POINT rs=%0d tv=0",
               state_dbg, remote_score, tx_valid, exp_r);
    end
    tick();
    want_s = model_win(exp_l, exp_r) ? MATCH_OVER : COUNTDOWN;
    n_vec++;
    if (state_dbg !== want_s || tx_valid !== 1'b0) begin
      n_miss++;
      $display("FAIL miss_after got st=%0d tv=%b want st=%0d tv=0", state_dbg, tx_valid, want_s);
    end
    for (int g = 0; g < 10 && !model_win(exp_l, exp_r); g++) begin
      wait_game_start();
      repeat (int'($urandom_range(0, 5))) tick();
      local_miss = 1'b1;
      tick();
      local_miss = 1'b0;
      exp_r++;
      n_vec++;
      if (state_dbg !== POINT || remote_score !== 8'(exp_r) || tx_valid !== 1'b0) begin
        n_miss++;
        $display("FAIL miss_point g=%0d got st=%0d rs=%0d tv=%b want POINT rs=%0d tv=0",
                 g, state_dbg, remote_score, tx_valid, exp_r);
      end
      tick();
    end
    n_vec++;
    if (state_dbg !== MATCH_OVER || match_over !== 1'b1) begin
      n_miss++;
      $display("FAIL match_over got st=%0d mo=%b want MATCH_OVER mo=1", state_dbg, match_over);
    end
    local_miss = 1'b1; rx_valid = 1'b1; rx_event = EV_MISS;
    tick();
    local_miss = 1'b0; rx_valid = 1'b0;
    n_vec++;
    if (state_dbg !== MATCH_OVER || local_score !== 8'(exp_l) || remote_score !== 8'(exp_r)) begin
      n_miss++;
      $display("FAIL over_ignores got st=%0d ls=%0d rs=%0d want MATCH_OVER %0d %0d",
               state_dbg, local_score, remote_score, exp_l, exp_r);
    end
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    ball_send_trigger = 1'b0;
    exp_l = 0;
    exp_r = 0;
    n_vec++;
    if (state_dbg !== COUNTDOWN || local_score !== 8'h00 || remote_score !== 8'h00 ||
        match_over !== 1'b0 || countdown_digit !== 2'(CS)) begin
      n_miss++;
      $display("FAIL restart_clear got st=%0d ls=%0d rs=%0d mo=%b cd=%0d want COUNTDOWN 0 0 0 %0d",
               state_dbg, local_score, remote_score, match_over, countdown_digit, CS);
    end
  endtask

  // Scripted run reaches 2-2, 3-2, 4-2 when the two-point-lead rule is active.
  task automatic test_match(input bit scripted);
    bit seq [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0] got;
    logic [7:0] want;
    int xfers;
    bit lw;
    state_t want_s;
    for (int i = 0; i < 40 && !model_win(exp_l, exp_r); i++) begin
      lw = scripted ? ((i < 6) ? seq[i] : 1'b1) : 1'($urandom_range(0, 1));
      wait_game_start();
      play_point(lw, got, xfers);
      if (lw) begin
        exp_l++;
        want = exp_q.pop_front();
        n_vec++;
        if (xfers != 1 || got !== want) begin
          n_miss++;
          $display("FAIL match_xfer i=%0d got n=%0d vy=%h want n=1 vy=%h", i, xfers, got, want);
        end
      end else begin
        exp_r++;
      end
      n_vec++;
      if (state_dbg !== POINT || local_score !== 8'(exp_l) || remote_score !== 8'(exp_r)) begin
        n_miss++;
        $display("FAIL match_score i=%0d got st=%0d ls=%0d rs=%0d want POINT %0d %0d",
                 i, state_dbg, local_score, remote_score, exp_l, exp_r);
      end
      tick();
      want_s = model_win(exp_l, exp_r) ? MATCH_OVER : COUNTDOWN;
      n_vec++;
      if (state_dbg !== want_s || match_over !== (want_s == MATCH_OVER)) begin
        n_miss++;
        $display("FAIL match_end i=%0d score %0d-%0d got st=%0d mo=%b want st=%0d",
                 i, exp_l, exp_r, state_dbg, match_over, want_s);
      end
    end
    n_vec++;
    if (state_dbg !== MATCH_OVER) begin
      n_miss++;
      $display("FAIL match_final got st=%0d want MATCH_OVER", state_dbg);
    end
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    exp_l = 0;
    exp_r = 0;
    n_vec++;
    if (state_dbg !== COUNTDOWN || local_score !== 8'h00 || remote_score !== 8'h00) begin
      n_miss++;
      $display("FAIL match_restart got st=%0d ls=%0d rs=%0d want COUNTDOWN 0 0",
               state_dbg, local_score, remote_score);
    end
  endtask

  task automatic test_reset_handoff();
    wait_game_start();
    ball_send_trigger = 1'b0;
    tx_ready = 1'b0;
    tick();
    ball_vy = 8'($urandom_range(1, 255));
    ball_send_trigger = 1'b1;
    tick();
    n_vec++;
    if (state_dbg !== HANDOFF || tx_valid !== 1'b1) begin
      n_miss++;
      $display("FAIL pre_reset got st=%0d tv=%b want HANDOFF tv=1", state_dbg, tx_valid);
    end
    #5;
    reset = 1'b1;
    #1;
    n_vec++;
    if (state_dbg !== IDLE || tx_valid !== 1'b0 || tx_vy !== 8'h00 || game_start !== 1'b0 ||
        local_score !== 8'h00 || remote_score !== 8'h00 || countdown_digit !== 2'd0 || match_over !== 1'b0) begin
      n_miss++;
      $display("FAIL async_reset got st=%0d tv=%b vy=%h gs=%b ls=%0d rs=%0d cd=%0d mo=%b want all 0",
               state_dbg, tx_valid, tx_vy, game_start, local_score, remote_score, countdown_digit, match_over);
    end
    @(negedge clk_25MHZ);
    reset = 1'b0;
    ball_send_trigger = 1'b0;
    tick();
    tick();
    n_vec++;
    if (state_dbg !== IDLE || tx_valid !== 1'b0) begin
      n_miss++;
      $display("FAIL post_reset got st=%0d tv=%b want IDLE tv=0", state_dbg, tx_valid);
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_handoff();
    test_remote_events();
    test_timeout();
    test_miss_vs_trigger();
    test_match(1'b1);
    test_match(1'b0);
    test_reset_handoff();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
